// File: rtl/i2c_master_slave_link_if.sv
// Request/response signal bundle for the I2C master/slave link.
// The "master" modport is the side that issues transfers and programs the
// slave address. The "slave" modport is the link block itself.
interface i2c_master_slave_link_if;
    logic [6:0] addr;
    logic [7:0] data_in;
    logic       enable;
    logic       rw;
    logic [7:0] data_out;
    logic       ready;
    logic [6:0] slave_addr;
    logic       ack;
    logic [7:0] slave_data_out;

    modport master (
        output addr, data_in, enable, rw, slave_addr,
        input  data_out, ready, ack, slave_data_out
    );

    modport slave (
        input  addr, data_in, enable, rw, slave_addr,
        output data_out, ready, ack, slave_data_out
    );
endinterface

// File: rtl/i2c_master_slave_link.sv
// Single-clock I2C master engine plus matching slave engine on one
// open-drain bus. Pins are only ever pulled to 0 or released.
// Bit timing: four phases of CLK_DIV clocks each.
//   ph0: SCL low, transmitter updates SDA at the end of ph0.
//   ph1: SCL low.
//   ph2: SCL released high, receiver samples SDA.
//   ph3: SCL high.
module i2c_master_slave_link #(
    parameter int CLK_DIV = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    i2c_master_slave_link_if.slave          link,
    inout  wire                             i2c_sda,
    inout  wire                             i2c_scl
);
    typedef enum logic [3:0] {
        M_IDLE, M_START, M_ADDR, M_ADDR_ACK, M_WDATA,
        M_WACK, M_RDATA, M_MNACK, M_STOP
    } m_state_t;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_AACK, S_RX, S_DACK, S_TX, S_IGNORE
    } s_state_t;

    m_state_t    m_state_r;
    logic [15:0] div_cnt_r;
    logic [1:0]  phase_r;
    logic [2:0]  m_bit_r;
    logic [7:0]  m_addr_byte_r;
    logic [7:0]  m_data_r;
    logic [7:0]  m_rx_r;
    logic        m_samp_r;
    logic        m_sda_low_r;
    logic        m_scl_low_r;
    logic        ready_r;
    logic [7:0]  data_out_r;

    s_state_t    s_state_r;
    logic [3:0]  s_cnt_r;
    logic [7:0]  s_sr_r;
    logic [7:0]  s_tx_r;
    logic        s_rw_r;
    logic        s_sda_low_r;
    logic        ack_r;
    logic [7:0]  slave_data_out_r;

    logic        sda_s1_r, sda_s2_r, sda_d_r;
    logic        scl_s1_r, scl_s2_r, scl_d_r;

    logic        tick_s;
    logic        start_det_s;
    logic        stop_det_s;
    logic        scl_rise_s;
    logic        scl_fall_s;

    // Open-drain pin drivers: either side may pull SDA, only the master pulls SCL.
    assign i2c_sda = (m_sda_low_r | s_sda_low_r) ? 1'b0 : 1'bz;
    assign i2c_scl = m_scl_low_r ? 1'b0 : 1'bz;

    assign link.data_out       = data_out_r;
    assign link.ready          = ready_r;
    assign link.ack            = ack_r;
    assign link.slave_data_out = slave_data_out_r;

    assign tick_s      = (div_cnt_r == 16'(CLK_DIV - 1));
    assign start_det_s = scl_s2_r & scl_d_r & sda_d_r & ~sda_s2_r;
    assign stop_det_s  = scl_s2_r & scl_d_r & ~sda_d_r & sda_s2_r;
    assign scl_rise_s  = scl_s2_r & ~scl_d_r;
    assign scl_fall_s  = ~scl_s2_r & scl_d_r;

    // Two-flop synchronizers on the bus pins plus one history stage for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sda_s1_r <= 1'b1;
            sda_s2_r <= 1'b1;
            sda_d_r  <= 1'b1;
            scl_s1_r <= 1'b1;
            scl_s2_r <= 1'b1;
            scl_d_r  <= 1'b1;
        end else begin
            sda_s1_r <= i2c_sda;
            sda_s2_r <= sda_s1_r;
            sda_d_r  <= sda_s2_r;
            scl_s1_r <= i2c_scl;
            scl_s2_r <= scl_s1_r;
            scl_d_r  <= scl_s2_r;
        end
    end

    // Master engine: phase divider, transaction FSM and registered pin/status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_state_r     <= M_IDLE;
            div_cnt_r     <= 16'd0;
            phase_r       <= 2'd0;
            m_bit_r       <= 3'd0;
            m_addr_byte_r <= 8'd0;
            m_data_r      <= 8'd0;
            m_rx_r        <= 8'd0;
            m_samp_r      <= 1'b1;
            m_sda_low_r   <= 1'b0;
            m_scl_low_r   <= 1'b0;
            ready_r       <= 1'b1;
            data_out_r    <= 8'd0;
        end else if (m_state_r == M_IDLE) begin
            div_cnt_r   <= 16'd0;
            phase_r     <= 2'd0;
            m_sda_low_r <= 1'b0;
            m_scl_low_r <= 1'b0;
            if (link.enable) begin
                m_addr_byte_r <= {link.addr, link.rw};
                m_data_r      <= link.data_in;
                ready_r       <= 1'b0;
                m_state_r     <= M_START;
            end else begin
                ready_r <= 1'b1;
            end
        end else if (tick_s) begin
            div_cnt_r <= 16'd0;
            phase_r   <= phase_r + 2'd1;
            case (phase_r)
                2'd0: begin
                    case (m_state_r)
                        M_START: m_sda_low_r <= 1'b0;
                        M_ADDR:  m_sda_low_r <= ~m_addr_byte_r[m_bit_r];
                        M_WDATA: m_sda_low_r <= ~m_data_r[m_bit_r];
                        M_STOP:  m_sda_low_r <= 1'b1;
                        default: m_sda_low_r <= 1'b0;   // release for ACK/NACK or read data
                    endcase
                end
                2'd1: begin
                    if (m_state_r == M_START) begin
                        m_sda_low_r <= 1'b1;            // START: SDA falls while SCL high
                    end else begin
                        m_scl_low_r <= 1'b0;
                    end
                end
                2'd2: begin
                    m_samp_r <= sda_s2_r;
                    if (m_state_r == M_RDATA) begin
                        m_rx_r <= {m_rx_r[6:0], sda_s2_r};
                        if (m_bit_r == 3'd0) begin
                            data_out_r <= {m_rx_r[6:0], sda_s2_r};
                        end
                    end else if (m_state_r == M_STOP) begin
                        m_sda_low_r <= 1'b0;            // STOP: SDA rises while SCL high
                    end
                end
                default: begin
                    m_scl_low_r <= (m_state_r != M_STOP);
                    case (m_state_r)
                        M_START: begin
                            m_state_r <= M_ADDR;
                            m_bit_r   <= 3'd7;
                        end
                        M_ADDR: begin
                            if (m_bit_r == 3'd0) m_state_r <= M_ADDR_ACK;
                            else                 m_bit_r   <= m_bit_r - 3'd1;
                        end
                        M_ADDR_ACK: begin
                            m_bit_r <= 3'd7;
                            if (m_samp_r)              m_state_r <= M_STOP;
                            else if (m_addr_byte_r[0]) m_state_r <= M_RDATA;
                            else                       m_state_r <= M_WDATA;
                        end
                        M_WDATA: begin
                            if (m_bit_r == 3'd0) m_state_r <= M_WACK;
                            else                 m_bit_r   <= m_bit_r - 3'd1;
                        end
                        M_RDATA: begin
                            if (m_bit_r == 3'd0) m_state_r <= M_MNACK;
                            else                 m_bit_r   <= m_bit_r - 3'd1;
                        end
                        M_WACK:  m_state_r <= M_STOP;
                        M_MNACK: m_state_r <= M_STOP;
                        M_STOP: begin
                            m_state_r <= M_IDLE;
                            ready_r   <= 1'b1;
                        end
                        default: m_state_r <= M_IDLE;
                    endcase
                end
            endcase
        end else begin
            div_cnt_r <= div_cnt_r + 16'd1;
        end
    end

    // Slave engine: START/STOP re-arm, address match, byte receive/transmit and ACK drive.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s_state_r        <= S_IDLE;
            s_cnt_r          <= 4'd0;
            s_sr_r           <= 8'd0;
            s_tx_r           <= 8'd0;
            s_rw_r           <= 1'b0;
            s_sda_low_r      <= 1'b0;
            ack_r            <= 1'b0;
            slave_data_out_r <= 8'd0;
        end else if (start_det_s) begin
            s_state_r   <= S_ADDR;
            s_cnt_r     <= 4'd0;
            s_sda_low_r <= 1'b0;
            ack_r       <= 1'b0;
        end else if (stop_det_s) begin
            s_state_r   <= S_IDLE;
            s_sda_low_r <= 1'b0;
            ack_r       <= 1'b0;
        end else begin
            case (s_state_r)
                S_ADDR: begin
                    if (scl_rise_s) begin
                        s_sr_r  <= {s_sr_r[6:0], sda_s2_r};
                        s_cnt_r <= s_cnt_r + 4'd1;
                    end else if (scl_fall_s && (s_cnt_r == 4'd8)) begin
                        if (s_sr_r[7:1] == link.slave_addr) begin
                            s_sda_low_r <= 1'b1;
                            ack_r       <= 1'b1;
                            s_rw_r      <= s_sr_r[0];
                            s_state_r   <= S_AACK;
                        end else begin
                            s_state_r <= S_IGNORE;
                        end
                    end
                end
                S_AACK: begin
                    if (scl_fall_s) begin
                        ack_r   <= 1'b0;
                        s_cnt_r <= 4'd0;
                        if (s_rw_r) begin
                            s_tx_r      <= slave_data_out_r;
                            s_sda_low_r <= ~slave_data_out_r[7];
                            s_state_r   <= S_TX;
                        end else begin
                            s_sda_low_r <= 1'b0;
                            s_state_r   <= S_RX;
                        end
                    end
                end
                S_RX: begin
                    if (scl_rise_s) begin
                        s_sr_r  <= {s_sr_r[6:0], sda_s2_r};
                        s_cnt_r <= s_cnt_r + 4'd1;
                        if (s_cnt_r == 4'd7) begin
                            slave_data_out_r <= {s_sr_r[6:0], sda_s2_r};
                        end
                    end else if (scl_fall_s && (s_cnt_r == 4'd8)) begin
                        s_sda_low_r <= 1'b1;
                        ack_r       <= 1'b1;
                        s_state_r   <= S_DACK;
                    end
                end
                S_DACK: begin
                    if (scl_fall_s) begin
                        s_sda_low_r <= 1'b0;
                        ack_r       <= 1'b0;
                        s_state_r   <= S_IGNORE;
                    end
                end
                S_TX: begin
                    if (scl_fall_s) begin
                        if (s_cnt_r == 4'd7) begin
                            s_sda_low_r <= 1'b0;        // release for the master's ACK/NACK
                            s_state_r   <= S_IGNORE;
                        end else begin
                            s_tx_r      <= {s_tx_r[6:0], 1'b0};
                            s_sda_low_r <= ~s_tx_r[6];
                            s_cnt_r     <= s_cnt_r + 4'd1;
                        end
                    end
                end
                S_IDLE, S_IGNORE: begin
                    s_sda_low_r <= 1'b0;
                end
                default: s_state_r <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_master_slave_link.sv
// Self-checking bench for i2c_master_slave_link: directed scenarios plus
// randomized transfers checked against a transaction-level slave model.
module tb_i2c_master_slave_link;
    logic clk = 1'b0;
    logic rst = 1'b0;
    wire  i2c_sda;
    wire  i2c_scl;

    pullup (i2c_sda);
    pullup (i2c_scl);

    i2c_master_slave_link_if link ();

    i2c_master_slave_link #(.CLK_DIV(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .link    (link),
        .i2c_sda (i2c_sda),
        .i2c_scl (i2c_scl)
    );

    always #5 clk = ~clk;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    // Bus observers: START/STOP conditions and ACK pulses.
    int   start_cnt = 0;
    int   stop_cnt  = 0;
    int   ack_cnt   = 0;
    logic sda_p = 1'b1;
    logic scl_p = 1'b1;
    logic ack_p = 1'b0;

    // Transaction-level model: one storage byte in the slave, last read byte in the master.
    logic [7:0] mdl_mem = 8'h00;
    logic [7:0] mdl_rd  = 8'h00;

    // Count bus conditions and ack rising edges on every clock.
    always @(posedge clk) begin
        if (scl_p && i2c_scl && (sda_p !== i2c_sda)) begin
            if (i2c_sda === 1'b0) start_cnt <= start_cnt + 1;
            else                  stop_cnt  <= stop_cnt + 1;
        end
        if (link.ack && !ack_p) ack_cnt <= ack_cnt + 1;
        sda_p <= i2c_sda;
        scl_p <= i2c_scl;
        ack_p <= link.ack;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (link.ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 32'(n < 1000), 32'd1);
    endtask

    // One complete transfer; expectations come from the model, not the DUT.
    task automatic run_txn(input logic [6:0] a, input logic [7:0] d, input logic r);
        int   s0, p0, k0, exp_ack;
        logic match;
        wait_ready("pre_ready");
        s0 = start_cnt; p0 = stop_cnt; k0 = ack_cnt;
        link.addr = a; link.data_in = d; link.rw = r; link.enable = 1'b1;
        @(negedge clk);
        check_val("busy", 32'(link.ready), 32'd0);
        repeat (4) @(negedge clk);
        link.enable = 1'b0;
        wait_ready("done");
        match = (a == link.slave_addr);
        if (match && !r) mdl_mem = d;
        if (match && r)  mdl_rd  = mdl_mem;
        exp_ack = match ? (r ? 1 : 2) : 0;
        check_val("slave_data_out", 32'(link.slave_data_out), 32'(mdl_mem));
        check_val("data_out", 32'(link.data_out), 32'(mdl_rd));
        check_val("ack_pulses", 32'(ack_cnt - k0), 32'(exp_ack));
        check_val("starts", 32'(start_cnt - s0), 32'd1);
        check_val("stops", 32'(stop_cnt - p0), 32'd1);
        check_val("ack_low", 32'(link.ack), 32'd0);
    endtask

    initial begin
        int         s0, p0, n;
        logic [7:0] d;
        logic [6:0] a;
        link.addr = 7'h00; link.data_in = 8'h00; link.enable = 1'b0;
        link.rw = 1'b0; link.slave_addr = 7'h2A;

        // Reset state
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check_val("rst_ready", 32'(link.ready), 32'd1);
        check_val("rst_data_out", 32'(link.data_out), 32'd0);
        check_val("rst_sdo", 32'(link.slave_data_out), 32'd0);
        check_val("rst_ack", 32'(link.ack), 32'd0);
        check_val("rst_sda", 32'(i2c_sda), 32'd1);
        check_val("rst_scl", 32'(i2c_scl), 32'd1);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Directed: write, address mismatch, read back
        run_txn(7'h2A, 8'h06, 1'b0);
        run_txn(7'h15, 8'hFF, 1'b0);
        run_txn(7'h2A, 8'h00, 1'b1);

        // Randomized transfers, occasionally retargeting the slave address
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) link.slave_addr = 7'($urandom);
            a = ($urandom_range(0, 1) == 1) ? link.slave_addr : 7'($urandom);
            run_txn(a, 8'($urandom), 1'($urandom));
        end

        // Back-to-back writes with enable held high
        link.slave_addr = 7'h2A; link.addr = 7'h2A; link.rw = 1'b0;
        wait_ready("b2b_pre");
        s0 = start_cnt; p0 = stop_cnt;
        d = 8'h07;
        link.data_in = d; link.enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            n = 0;
            while (link.ready !== 1'b1 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check_val("b2b_done", 32'(n < 1000), 32'd1);
            if (n >= 1000) break;
            check_val("b2b_sdo", 32'(link.slave_data_out), 32'(d));
            if (i == 99) begin
                link.enable = 1'b0;
            end else begin
                d = d + 8'd1;
                link.data_in = d;
            end
            @(negedge clk);
            if (i != 99) check_val("b2b_restart", 32'(link.ready), 32'd0);
        end
        mdl_mem = 8'h6A;
        check_val("b2b_final", 32'(link.slave_data_out), 32'h6A);
        check_val("b2b_starts", 32'(start_cnt - s0), 32'd100);
        check_val("b2b_stops", 32'(stop_cnt - p0), 32'd100);

        // Reset in the middle of the data byte
        wait_ready("mid_pre");
        link.addr = 7'h2A; link.data_in = 8'hA5; link.rw = 1'b0; link.enable = 1'b1;
        repeat (5) @(negedge clk);
        link.enable = 1'b0;
        repeat (195) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mdl_mem = 8'h00;
        mdl_rd  = 8'h00;
        check_val("mid_sda", 32'(i2c_sda), 32'd1);
        check_val("mid_scl", 32'(i2c_scl), 32'd1);
        check_val("mid_ready", 32'(link.ready), 32'd1);
        check_val("mid_sdo", 32'(link.slave_data_out), 32'(mdl_mem));
        check_val("mid_data_out", 32'(link.data_out), 32'(mdl_rd));
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        run_txn(7'h2A, 8'h55, 1'b0);
        run_txn(7'h2A, 8'h00, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end
endmodule

// File: doc/i2c_master_slave_link.md
Name: i2c_master_slave_link

Overview:
Single-clock I2C link block containing an I2C master engine and a matching I2C slave engine sharing one open-drain bus (i2c_sda/i2c_scl). The master performs one single-byte write or read transaction per enable request. The slave answers a programmable 7-bit address, stores written bytes, and returns its stored byte on reads. It is used as a self-contained bus endpoint pair for on-chip register transfer and bring-up.

Parameters:
CLK_DIV, 4, system clock cycles per SCL quarter-bit phase (min 2); one bit time = 4*CLK_DIV clk cycles.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset
addr  input  7  target slave address, sampled at transaction start
data_in  input  8  byte to write, sampled at transaction start
enable  input  1  transaction request, level-sampled while ready=1
rw  input  1  0=write, 1=read, sampled at transaction start
data_out  output  8  byte read by master
ready  output  1  master idle and accepting requests
i2c_sda  inout  1  open-drain SDA, drive 0 or release Z, pulled up
i2c_scl  inout  1  open-drain SCL (master drives), pulled up
slave_addr  input  7  slave's own address
ack  output  1  high while slave drives an ACK bit
slave_data_out  output  8  last byte received by slave

Behaviour:
- Reset (rst=0 at clk edge): master and slave release SDA/SCL (Z); ready=1; data_out=0; slave_data_out=0; ack=0; all FSMs in IDLE; phase counter cleared. A reset mid-transaction aborts without STOP; the bus is released the next cycle.
- Phase timing: tick every CLK_DIV clks. Per bit: ph0 SCL low, transmitter updates SDA; ph1 SCL low; ph2 SCL released high, receiver samples SDA; ph3 SCL high.
- Master FSM: IDLE -> START -> ADDR(8 bits: addr[6:0] MSB first, then rw) -> ADDR_ACK -> WDATA(8 bits MSB first) -> WACK -> STOP, or RDATA(8 bits) -> MNACK -> STOP; STOP -> IDLE.
- IDLE: SDA/SCL released; ready=1. If enable=1: latch addr/data_in/rw, ready=0 next cycle, enter START.
- START: SDA falls while SCL high, then SCL goes low. STOP: SDA low, SCL released, then SDA released after one phase.
- ADDR_ACK/WACK: master releases SDA and samples at ph2. SDA=1 (NACK): go to STOP, no data phase; data_out unchanged.
- RDATA: master releases SDA and shifts in 8 bits; data_out updates once when the 8th bit is sampled. MNACK: master leaves SDA released (NACK), then STOP.
- ready stays high through IDLE only. enable held high across a transaction end starts a new transaction immediately.
- Slave: samples SDA/SCL through a 2-flop synchronizer on clk. START = SDA fall with SCL high; STOP = SDA rise with SCL high; either resets the slave bit FSM (START re-arms address receive, STOP to IDLE).
- Slave shifts address+rw on SCL rises. On address match: drives SDA low for the ACK bit (from the SCL fall after the 8th bit to the next SCL fall), ack=1 for the same span. On mismatch: stays released and ignores the bus until the next START/STOP.
- Slave write: receives 8 bits, ACKs (ack=1), updates slave_data_out at the 8th-bit sample.
- Slave read: drives slave_data_out MSB first, changing SDA only while SCL is low, then releases SDA for the master's ACK/NACK and goes idle.
- Only 0 or Z is ever driven on the bus pins. The master never drives SCL high.

Test Plan:
- Reset: hold rst=0 for 50 clk -> ready=1, data_out=0x00, slave_data_out=0x00, ack=0, SDA/SCL=Z (pulled 1).
- Write: slave_addr=0x2A, addr=0x2A, data_in=0x06, rw=0, enable for 5 clk -> ready=0, ack pulses twice, slave_data_out=0x06, STOP seen, ready=1 within ~21 bit times.
- Address mismatch: addr=0x15, data_in=0xFF, write -> no ack, SDA=1 at ACK bit, STOP issued, slave_data_out stays 0x06, ready returns to 1.
- Read: after the 0x06 write, addr=0x2A, rw=1 -> data_out=0x06, master NACKs the last byte, ready returns to 1.
- Back-to-back: 100 writes to 0x2A, data incrementing from 0x07 each time ready=1 -> slave_data_out=0x6A at the end, no bus contention (never 0 from one side while the other expects release mid-bit).
- Reset mid-transfer: rst=0 during WDATA -> bus released next cycle, ready=1. A subsequent write of 0x55 is received correctly.
